// File: rtl/freq_meter.sv
// Frequency meter core: counts synchronized sig_in rising edges across one gate
// period and publishes the result in Hz as packed BCD, saturating on overflow.

module freq_meter_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic rise
);
   logic [SYNC_STAGES-1:0] sync;
   logic                   prev;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync <= '0;
         prev <= 1'b0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], din};
         prev <= sync[SYNC_STAGES-1];
      end
   end

   assign rise = sync[SYNC_STAGES-1] & ~prev;
endmodule

module freq_meter_bcd_digit (
   input  logic [3:0] digit,
   input  logic       cin,
   output logic [3:0] next,
   output logic       cout
);
   always_comb begin
      next = digit;
      cout = 1'b0;
      if (cin) begin
         if (digit >= 4'd9) begin
            next = 4'd0;
            cout = 1'b1;
         end else begin
            next = digit + 4'd1;
         end
      end
   end
endmodule

module freq_meter #(
   parameter int DIGITS      = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  sig_in,
   input  logic                  gate_1hz,
   input  logic                  gate_10hz,
   input  logic                  gate_100hz,
   input  logic                  gate_1khz,
   input  logic [1:0]            range_sel,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  valid,
   output logic                  overflow,
   output logic                  busy
);
   localparam int W  = 4*DIGITS;
   localparam int BW = $clog2(SYNC_STAGES+2);
   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

   typedef enum logic {ARM, MEASURE} state_t;

   state_t                 state, state_nx;
   logic [1:0]             rsel_q;
   logic                   gate_mux, gate_rise, sig_rise, gate_ev, range_chg;
   logic [BW-1:0]          blank;
   logic [DIGITS-1:0][3:0] cnt, cnt_nx, cnt_inc, nines;
   logic [DIGITS:0]        carry;
   logic                   ovf_acc, ovf_acc_nx;
   logic                   publish, res_ovf, top_nz;
   logic [W-1:0]           cnt_flat, shifted;

   always_comb begin
      case (range_sel)
         2'd0:    gate_mux = gate_1hz;
         2'd1:    gate_mux = gate_10hz;
         2'd2:    gate_mux = gate_100hz;
         default: gate_mux = gate_1khz;
      endcase
   end

   freq_meter_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sig_sync (
      .clk(clk), .reset(reset), .din(sig_in), .rise(sig_rise)
   );

   freq_meter_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_gate_sync (
      .clk(clk), .reset(reset), .din(gate_mux), .rise(gate_rise)
   );

   assign range_chg = (range_sel != rsel_q);
   // Switching the mux can fake a rising edge in the synchronizer; mask it out.
   assign gate_ev   = gate_rise && (blank == '0);

   assign carry[0] = 1'b1;
   genvar d;
   generate
      for (d = 0; d < DIGITS; d++) begin : g_dig
         freq_meter_bcd_digit u_dig (
            .digit(cnt[d]), .cin(carry[d]), .next(cnt_inc[d]), .cout(carry[d+1])
         );
         assign nines[d] = 4'd9;
      end
   endgenerate

   assign cnt_flat = cnt;
   assign shifted  = cnt_flat << {rsel_q, 2'b00};

   always_comb begin
      top_nz = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (i >= DIGITS - int'(rsel_q) && cnt[i] != 4'd0) top_nz = 1'b1;
      end
   end

   assign res_ovf = ovf_acc | top_nz;

   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      ovf_acc_nx = ovf_acc;
      publish    = 1'b0;
      if (range_chg) begin
         state_nx = ARM;
      end else begin
         case (state)
            ARM: begin
               if (gate_ev) begin
                  state_nx   = MEASURE;
                  cnt_nx     = sig_rise ? ONE : '0;
                  ovf_acc_nx = 1'b0;
               end
            end
            MEASURE: begin
               // A sig edge coincident with window end belongs to the new window.
               if (gate_ev) begin
                  publish    = 1'b1;
                  cnt_nx     = sig_rise ? ONE : '0;
                  ovf_acc_nx = 1'b0;
               end else if (sig_rise) begin
                  if (carry[DIGITS]) begin
                     cnt_nx     = nines;
                     ovf_acc_nx = 1'b1;
                  end else begin
                     cnt_nx = cnt_inc;
                  end
               end
            end
            default: state_nx = ARM;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= ARM;
         rsel_q  <= 2'd0;
         blank   <= '0;
         cnt     <= '0;
         ovf_acc <= 1'b0;
      end else begin
         state   <= state_nx;
         rsel_q  <= range_sel;
         cnt     <= cnt_nx;
         ovf_acc <= ovf_acc_nx;
         if (range_chg)          blank <= BW'(SYNC_STAGES+1);
         else if (blank != '0)   blank <= blank - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bcd_out  <= '0;
         overflow <= 1'b0;
         valid    <= 1'b0;
      end else begin
         valid <= publish;
         if (publish) begin
            bcd_out  <= res_ovf ? nines : shifted;
            overflow <= res_ovf;
         end
      end
   end

   assign busy = (state == MEASURE);
endmodule

// File: tb/tb_freq_meter.sv
// Scoreboard bench for freq_meter: an 8-digit and a 4-digit instance share the
// same stimulus; expected results are queued per window and popped on valid.

module tb_freq_meter;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        sig_in = 1'b0;
   logic        gate_1hz = 1'b0, gate_10hz = 1'b0, gate_100hz = 1'b0, gate_1khz = 1'b0;
   logic [1:0]  range_sel = 2'd0;
   logic [31:0] bcd8;
   logic [15:0] bcd4;
   logic        valid8, ovf8, busy8, valid4, ovf4, busy4;

   typedef struct packed {
      logic [31:0] bcd;
      logic        ovf;
   } exp_t;

   exp_t q8[$];
   exp_t q4[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   sig_per = 4, gate_per = 10, sig_ph = 0, gate_ph = 0;
   bit   gen_on = 1'b0, all_gates = 1'b0;
   logic g = 1'b0;

   always #5 clk = ~clk;

   freq_meter #(.DIGITS(8), .SYNC_STAGES(2)) dut8 (
      .clk(clk), .reset(reset), .sig_in(sig_in),
      .gate_1hz(gate_1hz), .gate_10hz(gate_10hz), .gate_100hz(gate_100hz), .gate_1khz(gate_1khz),
      .range_sel(range_sel), .bcd_out(bcd8), .valid(valid8), .overflow(ovf8), .busy(busy8)
   );

   freq_meter #(.DIGITS(4), .SYNC_STAGES(2)) dut4 (
      .clk(clk), .reset(reset), .sig_in(sig_in),
      .gate_1hz(gate_1hz), .gate_10hz(gate_10hz), .gate_100hz(gate_100hz), .gate_1khz(gate_1khz),
      .range_sel(range_sel), .bcd_out(bcd4), .valid(valid4), .overflow(ovf4), .busy(busy4)
   );

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   always @(negedge clk) begin : mon
      exp_t e;
      if (valid8 === 1'b1) begin
         if (q8.size() == 0) chk("dut8 unexpected valid", 32'(valid8), 32'd0);
         else begin
            e = q8.pop_front();
            chk("dut8 bcd_out", bcd8, e.bcd);
            chk("dut8 overflow", 32'(ovf8), 32'(e.ovf));
         end
      end
      if (valid4 === 1'b1) begin
         if (q4.size() == 0) chk("dut4 unexpected valid", 32'(valid4), 32'd0);
         else begin
            e = q4.pop_front();
            chk("dut4 bcd_out", 32'(bcd4), e.bcd);
            chk("dut4 overflow", 32'(ovf4), 32'(e.ovf));
         end
      end
   end

   function automatic void drive_gates();
      gate_1hz   = g && (all_gates || range_sel == 2'd0);
      gate_10hz  = g && (all_gates || range_sel == 2'd1);
      gate_100hz = g && (all_gates || range_sel == 2'd2);
      gate_1khz  = g && (all_gates || range_sel == 2'd3);
   endfunction

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (gen_on) begin
            sig_in  = (sig_ph < sig_per/2);
            g       = (gate_ph < gate_per/2);
            sig_ph  = (sig_ph  == sig_per-1)  ? 0 : sig_ph + 1;
            gate_ph = (gate_ph == gate_per-1) ? 0 : gate_ph + 1;
         end else begin
            sig_in = 1'b0;
            g      = 1'b0;
         end
         drive_gates();
      end
   endtask

   task automatic check_idle(input string tag);
      chk({tag, " dut8 bcd_out"},  bcd8, 32'd0);
      chk({tag, " dut8 valid"},    32'(valid8), 32'd0);
      chk({tag, " dut8 overflow"}, 32'(ovf8), 32'd0);
      chk({tag, " dut8 busy"},     32'(busy8), 32'd0);
      chk({tag, " dut4 bcd_out"},  32'(bcd4), 32'd0);
      chk({tag, " dut4 busy"},     32'(busy4), 32'd0);
   endtask

   // Reset, select range, then run k full windows from a fresh gate edge.
   task automatic start(input logic [1:0] rs, input int sp, input int gp);
      #2 reset = 1'b0;
      gen_on = 1'b0;
      all_gates = 1'b0;
      range_sel = rs;
      step(3);
      #2 reset = 1'b1;
      step(8);
      sig_per = sp; gate_per = gp; sig_ph = 0; gate_ph = 0;
      gen_on = 1'b1;
   endtask

   task automatic push(input int k, input logic [31:0] e8, input logic o8,
                       input logic [15:0] e4, input logic o4);
      for (int i = 0; i < k; i++) begin
         q8.push_back('{bcd: e8, ovf: o8});
         q4.push_back('{bcd: 32'(e4), ovf: o4});
      end
   endtask

   task automatic drained(input string tag);
      chk({tag, " dut8 pending windows"}, 32'(q8.size()), 32'd0);
      chk({tag, " dut4 pending windows"}, 32'(q4.size()), 32'd0);
      q8.delete();
      q4.delete();
   endtask

   task automatic phase(input string tag, input logic [1:0] rs, input int sp, input int gp,
                        input int k, input logic [31:0] e8, input logic o8,
                        input logic [15:0] e4, input logic o4);
      start(rs, sp, gp);
      push(k, e8, o8, e4, o4);
      step(k*gp + 20);
      drained(tag);
      chk({tag, " dut8 busy in window"}, 32'(busy8), 32'd1);
   endtask

   initial begin
      // Reset held with every input toggling.
      gen_on = 1'b1; all_gates = 1'b1;
      step(20);
      check_idle("reset@20");
      step(30);
      check_idle("reset@50");

      phase("r0 sig8",     2'd0, 8,  2000,  3, 32'h0000_0250, 1'b0, 16'h0250, 1'b0);
      phase("r2 sig20",    2'd2, 20, 2000,  2, 32'h0001_0000, 1'b0, 16'h9999, 1'b1);
      phase("r3 sig4",     2'd3, 4,  400,   2, 32'h0010_0000, 1'b0, 16'h9999, 1'b1);
      phase("r0 wrap",     2'd0, 4,  40004, 1, 32'h0001_0001, 1'b0, 16'h9999, 1'b1);
      phase("coincident",  2'd0, 10, 1000,  3, 32'h0000_0100, 1'b0, 16'h0100, 1'b0);

      // Range change mid-window discards it; outputs hold until next valid.
      start(2'd0, 8, 2000);
      push(1, 32'h0000_0250, 1'b0, 16'h0250, 1'b0);
      step(2500);
      drained("abort pre");
      chk("abort dut8 busy before", 32'(busy8), 32'd1);
      range_sel = 2'd1;
      drive_gates();
      step(1);
      chk("abort dut8 busy after", 32'(busy8), 32'd0);
      chk("abort dut8 bcd hold",   bcd8, 32'h0000_0250);
      chk("abort dut8 ovf hold",   32'(ovf8), 32'd0);
      chk("abort dut4 bcd hold",   32'(bcd4), 32'h0000_0250);
      push(1, 32'h0000_2500, 1'b0, 16'h2500, 1'b0);
      step(6020 - 2501);
      drained("abort x10");

      // Async reset mid-window clears outputs without a clock edge.
      step(500);
      chk("midreset dut8 busy before", 32'(busy8), 32'd1);
      #3 reset = 1'b0;
      #1 check_idle("midreset");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
Frequency-measurement core that consumes the 1 Hz/10 Hz/100 Hz/1 kHz square-wave gate clocks from the frequency-meter clock divider. It counts rising edges of an external signal over one full gate period and publishes the result in Hz as packed BCD for the display path. All logic runs on the 50 MHz system clock. Gate and signal inputs are treated as asynchronous and sampled; none is used as a clock.

Parameters:
DIGITS, 8, number of BCD result digits (result range 0 .. 10^DIGITS-1 Hz)
SYNC_STAGES, 2, flip-flop stages in each input synchronizer (minimum 2)

Ports:
clk  input  1  system clock, 50 MHz
reset  input  1  asynchronous, active-low reset
sig_in  input  1  signal under measurement, asynchronous
gate_1hz  input  1  1 Hz square wave (1 s window)
gate_10hz  input  1  10 Hz square wave (0.1 s window)
gate_100hz  input  1  100 Hz square wave (10 ms window)
gate_1khz  input  1  1 kHz square wave (1 ms window)
range_sel  input  2  0=1hz, 1=10hz, 2=100hz, 3=1khz gate; quasi-static
bcd_out  output  4*DIGITS  latched frequency in Hz, packed BCD, digit 0 in [3:0]
valid  output  1  one-cycle pulse when bcd_out/overflow are updated
overflow  output  1  latched with bcd_out: result exceeded DIGITS digits
busy  output  1  high while a measurement window is open (MEASURE state)

Behaviour:
- Reset (async, reset=0): bcd_out=0, valid=0, overflow=0, busy=0, all counters and synchronizers 0, FSM=ARM.
- Synchronization: sig_in and the selected gate each pass through SYNC_STAGES flops. A rising-edge detector on each uses one extra registered stage. Each detector outputs a one-cycle edge strobe.
- Gate mux: range_sel selects the gate feeding the gate synchronizer. range_sel is registered as rsel_q.
- Range change: any cycle where range_sel != rsel_q forces FSM to ARM. The open window is discarded, no valid is issued, and rsel_q takes the new value.
- ARM:
  - busy=0.
  - On a gate rising strobe: clear the BCD counter to 0 (or 1 if a sig strobe occurs in the same cycle), clear ovf_acc, go to MEASURE.
- MEASURE:
  - busy=1.
  - Each sig strobe increments the BCD counter by 1, with decimal carry per digit (9 -> 0, carry into the next digit).
  - Carry out of the top digit sets ovf_acc. The counter then saturates at all 9s.
  - On a gate rising strobe (window end), in cycle T:
    - Shift the count left by S = rsel_q digits (S = 0..3), so the result is in Hz.
    - Overflow = ovf_acc OR any of the top S digits of the count nonzero. If overflow, bcd_out = all 9s; otherwise bcd_out = shifted count.
    - bcd_out and overflow update at T+1, with valid=1 for exactly the T+1 cycle.
    - The counter restarts in cycle T per the ARM rule. FSM stays in MEASURE, so measurement is back-to-back with no dead cycle.
- Simultaneous events: a sig strobe in the same cycle as the window-end gate strobe counts into the new window, never the old one.
- Latency: a sig_in or gate edge at the pin reaches its strobe in SYNC_STAGES+1 cycles. The same delay applies to both, so window alignment is preserved.
- Input limits:
  - sig_in high and low times must each be ≥ 2 clk periods. Faster input is undercounted; this is not flagged.
  - A gate glitch shorter than SYNC_STAGES cycles has undefined effect.
- bcd_out and overflow hold their last value between valid pulses and across range changes until the next valid.
- Reset mid-window: all state clears asynchronously and the partial count is lost. After release the FSM waits in ARM for a full gate period before the first valid.
- The first gate rising edge after reset or a range change only opens a window; the first valid comes at the second edge.

Test Plan:
- Gates are bench-driven with short periods for simulation; the scale factor depends only on range_sel.
- Reset: hold reset=0 with all inputs toggling -> bcd_out=0, valid=0, overflow=0, busy=0; after release, no valid before the second gate rising edge.
- Range 0: gate period 2000 clk, sig period 8 clk -> every window after the first gives valid with bcd_out=0x00000250, overflow=0; valid is exactly 1 cycle wide.
- Range 2: sig period 20 clk, gate period 2000 clk -> count 100, bcd_out=0x00010000 (10000 Hz), overflow=0; BCD carries 99 -> 100 are correct.
- Overflow:
  - Range 3, DIGITS=4, sig period 4 clk, gate period 400 clk -> count 100, shift 3 -> overflow=1, bcd_out=0x9999.
  - Range 0, DIGITS=4, sig period 4 clk, gate period 40004 clk -> count wraps past 9999 -> overflow=1, bcd_out=0x9999.
- Coincident edges: align a sig rising edge with each gate rising edge, gate period 1000 clk, sig period 10 clk -> every window reads exactly 100 (no double or missed count).
- Abort: change range_sel 0 -> 1 mid-window -> no valid for that window, busy drops the next cycle, bcd_out holds its previous value; the next valid reflects the ×10 scale. An async reset pulse mid-window -> all outputs 0 immediately.
